// File: rtl/snake_pkg.sv
// snake_pkg: shared constants, state encoding and helpers for the snake core.
// Direction encoding is one-hot {up,down,left,right}.
package snake_pkg;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    localparam int INIT_LEN = 3;

    typedef enum logic [1:0] {
        S_PLACE,
        S_RUN,
        S_OVER
    } state_t;

    function automatic logic [3:0] dir_reverse(input logic [3:0] d);
        logic [3:0] r;
        r = 4'b0000;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic int unsigned xy_to_idx(
        input int unsigned x,
        input int unsigned y,
        input int unsigned w
    );
        return y * w + x;
    endfunction

    function automatic int unsigned idx_to_x(input int unsigned idx, input int unsigned w);
        return idx % w;
    endfunction

    function automatic int unsigned idx_to_y(input int unsigned idx, input int unsigned w);
        return idx / w;
    endfunction

endpackage

// File: rtl/snake_engine_bcd.sv
// bcd_counter: saturating multi-digit BCD up-counter with synchronous clear.
// Holds at all nines instead of wrapping.
module bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                inc,
    output logic [4*DIGITS-1:0] value
);

    logic [4*DIGITS-1:0] value_next;
    logic                all_nines;
    logic                carry;

    always_comb begin
        all_nines  = 1'b1;
        carry      = 1'b1;
        value_next = value;
        for (int i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    value_next[4*i +: 4] = 4'd0;
                end else begin
                    value_next[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            value <= '0;
        end else if (inc && !all_nines) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/snake_engine.sv
// snake_engine: snake body ring buffer, occupancy grid, food, tick and score.
// Build option SNAKE_WRAP_EN: wall exits wrap to the opposite edge.
module snake_engine
    import snake_pkg::*;
#(
    parameter int CELLS_WIDTH  = 32,
    parameter int CELLS_HEIGHT = 32,
    parameter int CELL_BITS    = $clog2(CELLS_WIDTH*CELLS_HEIGHT),
    parameter int MAX_LEN      = 256,
    parameter int TICK_DIV     = 5323500,
    parameter int SCORE_DIGITS = 4
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Rst,
    input  logic                                 i_Start,
    input  logic                                 i_Pause,
    input  logic [3:0]                           i_Direction,
    input  logic [CELL_BITS-1:0]                 i_Rng,
    output logic [CELLS_WIDTH*CELLS_HEIGHT-1:0]  o_Grid,
    output logic [CELL_BITS-1:0]                 o_Food,
    output logic                                 o_FoodValid,
    output logic [$clog2(MAX_LEN+1)-1:0]         o_Length,
    output logic [4*SCORE_DIGITS-1:0]            o_Score,
    output logic                                 o_Tick,
    output logic                                 o_GameOver,
    output logic                                 o_Win
);

    localparam int unsigned CELLS = CELLS_WIDTH * CELLS_HEIGHT;
    localparam int XB        = $clog2(CELLS_WIDTH);
    localparam int YB        = $clog2(CELLS_HEIGHT);
    localparam int PTR_BITS  = $clog2(MAX_LEN);
    localparam int LEN_BITS  = $clog2(MAX_LEN + 1);
    localparam int TICK_BITS = $clog2(TICK_DIV);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [CELL_BITS-1:0] INIT_HEAD =
        CELL_BITS'(xy_to_idx(CELLS_WIDTH/2, CELLS_HEIGHT/2, CELLS_WIDTH));
    localparam logic [CELL_BITS-1:0] INIT_MID =
        CELL_BITS'(xy_to_idx(CELLS_WIDTH/2 - 1, CELLS_HEIGHT/2, CELLS_WIDTH));
    localparam logic [CELL_BITS-1:0] INIT_TAIL =
        CELL_BITS'(xy_to_idx(CELLS_WIDTH/2 - 2, CELLS_HEIGHT/2, CELLS_WIDTH));

    state_t state;
    state_t next_state;

    logic [CELL_BITS-1:0] body [MAX_LEN];
    logic [PTR_BITS-1:0]  head_ptr;
    logic [PTR_BITS-1:0]  tail_ptr;
    logic [PTR_BITS-1:0]  head_nxt;
    logic [XB-1:0]        head_x;
    logic [XB-1:0]        nx;
    logic [YB-1:0]        head_y;
    logic [YB-1:0]        ny;
    logic [3:0]           dir;
    logic [3:0]           last_dir;
    logic [3:0]           ref_dir;
    logic [TICK_BITS-1:0] tick_cnt;
    logic [CELLS-1:0]     grid;
    logic [CELL_BITS-1:0] food;
    logic                 food_valid;
    logic [LEN_BITS-1:0]  length;
    logic [LEN_BITS-1:0]  grown_len;
    logic                 win;

    logic [CELL_BITS-1:0] next_idx;
    logic [CELL_BITS-1:0] tail_cell;
    logic                 wall;
    logic                 grow;
    logic                 self_hit;
    logic                 tick;
    logic                 accept;
    logic                 init;
    logic                 dir_ok;
    logic                 step_move;
    logic                 step_win;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(MAX_LEN - 1)) ? '0 : p + PTR_BITS'(1);
    endfunction

    assign init   = i_Rst || (state == S_OVER && i_Start);
    assign tick   = (state == S_RUN) && !i_Pause &&
                    (tick_cnt == TICK_BITS'(TICK_DIV - 1));
    assign accept = (state == S_PLACE) && (32'(i_Rng) < CELLS) && !grid[i_Rng];

    // On a step cycle the latched direction is being committed, so filter
    // new input against it rather than the previous step.
    assign ref_dir = tick ? dir : last_dir;
    assign dir_ok  = (state != S_OVER) && $onehot(i_Direction) &&
                     (i_Direction != dir_reverse(ref_dir));

    always_comb begin
        nx   = head_x;
        ny   = head_y;
        wall = 1'b0;
        unique case (1'b1)
            dir[3]: begin
                if (head_y == '0) begin
                    if (WRAP) ny = YB'(CELLS_HEIGHT - 1);
                    else      wall = 1'b1;
                end else begin
                    ny = head_y - YB'(1);
                end
            end
            dir[2]: begin
                if (head_y == YB'(CELLS_HEIGHT - 1)) begin
                    if (WRAP) ny = '0;
                    else      wall = 1'b1;
                end else begin
                    ny = head_y + YB'(1);
                end
            end
            dir[1]: begin
                if (head_x == '0) begin
                    if (WRAP) nx = XB'(CELLS_WIDTH - 1);
                    else      wall = 1'b1;
                end else begin
                    nx = head_x - XB'(1);
                end
            end
            dir[0]: begin
                if (head_x == XB'(CELLS_WIDTH - 1)) begin
                    if (WRAP) nx = '0;
                    else      wall = 1'b1;
                end else begin
                    nx = head_x + XB'(1);
                end
            end
            default: wall = 1'b0;
        endcase
    end

    assign next_idx  = CELL_BITS'(xy_to_idx(32'(nx), 32'(ny), CELLS_WIDTH));
    assign tail_cell = body[tail_ptr];
    assign head_nxt  = ptr_inc(head_ptr);
    assign grow      = food_valid && (next_idx == food);
    // Entering the cell the tail is vacating this step is legal.
    assign self_hit  = !wall && grid[next_idx] && !(next_idx == tail_cell && !grow);
    assign step_move = tick && !wall && !self_hit;
    assign grown_len = length + LEN_BITS'(1);
    assign step_win  = step_move && grow && (grown_len == LEN_BITS'(MAX_LEN));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) state <= S_PLACE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_PLACE: if (accept) next_state = S_RUN;
            S_RUN: begin
                if (tick) begin
                    if (wall || self_hit) next_state = S_OVER;
                    else if (grow)        next_state = step_win ? S_OVER : S_PLACE;
                end
            end
            S_OVER:  if (i_Start) next_state = S_PLACE;
            default: next_state = S_PLACE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (init) begin
            grid            <= '0;
            grid[INIT_HEAD] <= 1'b1;
            grid[INIT_MID]  <= 1'b1;
            grid[INIT_TAIL] <= 1'b1;
            body[0]         <= INIT_TAIL;
            body[1]         <= INIT_MID;
            body[2]         <= INIT_HEAD;
            tail_ptr        <= '0;
            head_ptr        <= PTR_BITS'(INIT_LEN - 1);
            head_x          <= XB'(CELLS_WIDTH / 2);
            head_y          <= YB'(CELLS_HEIGHT / 2);
            dir             <= DIR_RIGHT;
            last_dir        <= DIR_RIGHT;
            length          <= LEN_BITS'(INIT_LEN);
            food            <= '0;
            food_valid      <= 1'b0;
            win             <= 1'b0;
            tick_cnt        <= '0;
        end else begin
            if (dir_ok) dir <= i_Direction;
            if (tick)   last_dir <= dir;
            if (state == S_RUN && !i_Pause) begin
                tick_cnt <= tick ? '0 : tick_cnt + TICK_BITS'(1);
            end
            if (accept) begin
                food       <= i_Rng;
                food_valid <= 1'b1;
            end
            if (step_move) begin
                head_ptr       <= head_nxt;
                body[head_nxt] <= next_idx;
                head_x         <= nx;
                head_y         <= ny;
                if (grow) begin
                    length     <= grown_len;
                    food_valid <= 1'b0;
                end else begin
                    tail_ptr        <= ptr_inc(tail_ptr);
                    grid[tail_cell] <= 1'b0;
                end
                grid[next_idx] <= 1'b1;
            end
            if (step_win) win <= 1'b1;
        end
    end

    bcd_counter #(
        .DIGITS(SCORE_DIGITS)
    ) u_score (
        .clk  (i_Clk),
        .clr  (init),
        .inc  (step_move && grow),
        .value(o_Score)
    );

    assign o_Grid      = grid;
    assign o_Food      = food;
    assign o_FoodValid = food_valid;
    assign o_Length    = length;
    assign o_Tick      = tick;
    assign o_GameOver  = (state == S_OVER);
    assign o_Win       = win;

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed checks of snake_engine on an 8x8 grid, TICK_DIV=8.
// A second instance with MAX_LEN=4 shares the stimulus to cover the win path.
module tb_snake_engine;

    localparam int CB = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [3:0]    dir = 4'b0;
    logic [CB-1:0] rng = '0;

    logic [63:0]   grid;
    logic [CB-1:0] food;
    logic          fv;
    logic [8:0]    len;
    logic [15:0]   score;
    logic          tick;
    logic          over;
    logic          win;

    logic [63:0]   grid2;
    logic [CB-1:0] food2;
    logic          fv2;
    logic [2:0]    len2;
    logic [15:0]   score2;
    logic          tick2;
    logic          over2;
    logic          win2;

    int total = 0;
    int bad = 0;

    logic [CB-1:0] eat_cells [9] = '{6'd38, 6'd39, 6'd31, 6'd30, 6'd29,
                                     6'd28, 6'd27, 6'd26, 6'd25};
    logic [3:0]    eat_dirs  [9] = '{4'b0000, 4'b0000, 4'b1000, 4'b0010, 4'b0000,
                                     4'b0000, 4'b0000, 4'b0000, 4'b0000};

    always #5 clk = ~clk;

    snake_engine #(
        .CELLS_WIDTH (8),
        .CELLS_HEIGHT(8),
        .MAX_LEN     (256),
        .TICK_DIV    (8),
        .SCORE_DIGITS(4)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Pause(pause),
        .i_Direction(dir), .i_Rng(rng),
        .o_Grid(grid), .o_Food(food), .o_FoodValid(fv), .o_Length(len),
        .o_Score(score), .o_Tick(tick), .o_GameOver(over), .o_Win(win)
    );

    snake_engine #(
        .CELLS_WIDTH (8),
        .CELLS_HEIGHT(8),
        .MAX_LEN     (4),
        .TICK_DIV    (8),
        .SCORE_DIGITS(4)
    ) dut_win (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Pause(pause),
        .i_Direction(dir), .i_Rng(rng),
        .o_Grid(grid2), .o_Food(food2), .o_FoodValid(fv2), .o_Length(len2),
        .o_Score(score2), .o_Tick(tick2), .o_GameOver(over2), .o_Win(win2)
    );

    task automatic do_reset(input logic [CB-1:0] r);
        rst = 1'b1; start = 1'b0; pause = 1'b0; dir = 4'b0; rng = r;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns on the negedge just after a step edge; dir is held one edge.
    task automatic wait_step(input string tag);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            dir = 4'b0;
            n++;
            if (tick) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            $display("FAIL %s: no o_Tick within 100 cycles", tag);
            bad++;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset(6'd36);
        total++; if (grid !== 64'h0000_001C_0000_0000) begin
            $display("FAIL rst_grid: got %h want %h", grid, 64'h0000_001C_0000_0000); bad++; end
        total++; if (len !== 9'd3) begin
            $display("FAIL rst_len: got %0d want 3", len); bad++; end
        total++; if (score !== 16'h0000) begin
            $display("FAIL rst_score: got %h want 0000", score); bad++; end
        total++; if (over !== 1'b0 || fv !== 1'b0 || tick !== 1'b0 || win !== 1'b0) begin
            $display("FAIL rst_flags: got over=%b fv=%b tick=%b win=%b want 0000",
                     over, fv, tick, win); bad++; end
        repeat (3) @(negedge clk);
        total++; if (fv !== 1'b0) begin
            $display("FAIL place_occupied: got fv=%b want 0", fv); bad++; end
        rng = 6'd0;
        @(negedge clk);
        total++; if (fv !== 1'b1 || food !== 6'd0) begin
            $display("FAIL place_zero: got fv=%b food=%0d want fv=1 food=0", fv, food); bad++; end
    endtask

    task automatic test_move();
        int n = 0;
        bit seen = 1'b0;
        wait_step("move1");
        total++; if (grid !== 64'h0000_0038_0000_0000) begin
            $display("FAIL move1_grid: got %h want %h", grid, 64'h0000_0038_0000_0000); bad++; end
        dir = 4'b0010;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            dir = (n == 1) ? 4'b0011 : 4'b0000;
            if (tick) seen = 1'b1;
        end
        total++; if (n + 1 !== 8) begin
            $display("FAIL tick_period: got %0d want 8", n + 1); bad++; end
        @(negedge clk);
        total++; if (grid !== 64'h0000_0070_0000_0000) begin
            $display("FAIL dir_ignore: got %h want %h", grid, 64'h0000_0070_0000_0000); bad++; end
        dir = 4'b1000;
        pause = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            dir = 4'b0;
            if (tick) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin
            $display("FAIL pause: got tick=%b want 0", seen); bad++; end
        pause = 1'b0;
        wait_step("move_up");
        total++; if (grid !== 64'h0000_0060_4000_0000) begin
            $display("FAIL dir_up: got %h want %h", grid, 64'h0000_0060_4000_0000); bad++; end
    endtask

    task automatic test_eat();
        logic [15:0] exp_sc;
        do_reset(6'd37);
        wait_step("eat1");
        total++; if (len !== 9'd4 || score !== 16'h0001 || fv !== 1'b0) begin
            $display("FAIL eat1: got len=%0d score=%h fv=%b want 4 0001 0", len, score, fv); bad++; end
        total++; if (over2 !== 1'b1 || win2 !== 1'b1 || len2 !== 3'd4) begin
            $display("FAIL win: got over=%b win=%b len=%0d want 1 1 4", over2, win2, len2); bad++; end
        for (int i = 0; i < 9; i++) begin
            rng = eat_cells[i];
            dir = eat_dirs[i];
            wait_step("eat_n");
            exp_sc = (i == 8) ? 16'h0010 : 16'(i + 2);
            total++; if (score !== exp_sc || len !== 9'(i + 5)) begin
                $display("FAIL eat_%0d: got score=%h len=%0d want %h %0d",
                         i + 2, score, len, exp_sc, i + 5); bad++; end
        end
    endtask

    task automatic test_wall();
        do_reset(6'd0);
        repeat (4) wait_step("wall");
`ifdef SNAKE_WRAP_EN
        total++; if (over !== 1'b0 || grid !== 64'h0000_00C1_0000_0000) begin
            $display("FAIL wrap: got over=%b grid=%h want 0 %h",
                     over, grid, 64'h0000_00C1_0000_0000); bad++; end
`else
        total++; if (over !== 1'b1 || win !== 1'b0) begin
            $display("FAIL wall: got over=%b win=%b want 1 0", over, win); bad++; end
        total++; if (grid !== 64'h0000_00E0_0000_0000) begin
            $display("FAIL wall_grid: got %h want %h", grid, 64'h0000_00E0_0000_0000); bad++; end
        repeat (10) @(negedge clk);
        total++; if (over !== 1'b1 || tick !== 1'b0) begin
            $display("FAIL over_hold: got over=%b tick=%b want 1 0", over, tick); bad++; end
`endif
    endtask

    task automatic test_self_hit();
        do_reset(6'd37);
        wait_step("sh_eat1");
        rng = 6'd38;
        wait_step("sh_eat2");
        rng = 6'd0;
        dir = 4'b1000;
        wait_step("sh_up");
        dir = 4'b0010;
        wait_step("sh_left");
        dir = 4'b0100;
        wait_step("sh_down");
        total++; if (over !== 1'b1 || win !== 1'b0) begin
            $display("FAIL self_hit: got over=%b win=%b want 1 0", over, win); bad++; end
        total++; if (grid !== 64'h0000_0070_6000_0000) begin
            $display("FAIL self_grid: got %h want %h", grid, 64'h0000_0070_6000_0000); bad++; end
        total++; if (score !== 16'h0002 || len !== 9'd5) begin
            $display("FAIL self_score: got %h len=%0d want 0002 5", score, len); bad++; end
    endtask

    task automatic test_restart();
        rng = 6'd36;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (grid !== 64'h0000_001C_0000_0000 || len !== 9'd3 || score !== 16'h0) begin
            $display("FAIL restart: got grid=%h len=%0d score=%h want %h 3 0000",
                     grid, len, score, 64'h0000_001C_0000_0000); bad++; end
        total++; if (over !== 1'b0 || fv !== 1'b0 || win !== 1'b0) begin
            $display("FAIL restart_flags: got over=%b fv=%b win=%b want 000", over, fv, win); bad++; end
        total++; if (over2 !== 1'b0 || win2 !== 1'b0 || len2 !== 3'd3) begin
            $display("FAIL restart_win: got over=%b win=%b len=%0d want 0 0 3",
                     over2, win2, len2); bad++; end
        rng = 6'd0;
        wait_step("restart_move");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (grid !== 64'h0000_0038_0000_0000 || len !== 9'd3) begin
            $display("FAIL start_ignored: got grid=%h len=%0d want %h 3",
                     grid, len, 64'h0000_0038_0000_0000); bad++; end
    endtask

    initial begin
        test_reset();
        test_move();
        test_eat();
        test_wall();
        test_self_hit();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
